// File: rtl/mem_stage_lsu_pkg.sv
// Shared MEM-stage definitions: func3 encodings, LSU state encoding, pipeline payloads.
package mem_stage_lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;
  localparam int unsigned WD_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RDATA
  } lsu_state_e;

  // EX/MEM memory-access fields as carried by the pipeline register
  typedef struct packed {
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      func3;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rd_two;
  } ex_mem_acc_t;

  typedef struct packed {
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } dm_lane_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering, load extraction/extension and access legality decode.
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      func3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output dm_lane_t        lane,
  output logic [XLEN-1:0] load_data,
  output logic            legal
);

  logic [XLEN-1:0] rd_shift;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic            f3_ok_rd;
  logic            f3_ok_wr;
  logic            misaligned;

  // Size is func3[1:0] for both loads and stores
  always_comb begin
    lane = '0;
    case (func3[1:0])
      2'b00: begin
        lane.be    = BE_W'(4'b0001 << addr_lo);
        lane.wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        lane.be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane.wdata = {2{store_data[15:0]}};
      end
      2'b10: begin
        lane.be    = 4'b1111;
        lane.wdata = store_data;
      end
      default: lane = '0;
    endcase
  end

  always_comb begin
    rd_shift  = rdata >> {addr_lo, 3'b000};
    rd_byte   = rd_shift[7:0];
    rd_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = '0;
    case (func3)
      F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'd0, rd_byte};
      F3_HU:   load_data = {16'd0, rd_half};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    f3_ok_rd   = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
                 (func3 == F3_BU) || (func3 == F3_HU);
    f3_ok_wr   = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
    misaligned = ((func3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));
    legal      = (mem_read ^ mem_write) && (mem_read ? f3_ok_rd : f3_ok_wr) && !misaligned;
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/gnt/rvalid handshake FSM, watchdog and pipeline stall.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned DM_AW       = 9,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       func3,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  store_data,
  output logic             dm_req,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [BE_W-1:0]  dm_be,
  output logic [XLEN-1:0]  dm_wdata,
  input  logic             dm_gnt,
  input  logic             dm_rvalid,
  input  logic [XLEN-1:0]  dm_rdata,
  output logic [XLEN-1:0]  load_data,
  output logic             done,
  output logic             stall,
  output logic             access_err,
  output logic             bus_err
);

  lsu_state_e      state_q, state_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  dm_lane_t        lane;
  logic [XLEN-1:0] ext_data;
  logic            legal;
  logic            access_c;
  logic            timeout_c;
  logic            unused_addr_hi;

  lsu_align u_align (
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .func3      (func3),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .rdata      (dm_rdata),
    .lane       (lane),
    .load_data  (ext_data),
    .legal      (legal)
  );

  assign unused_addr_hi = ^addr[XLEN-1:DM_AW];
  assign access_c       = mem_read | mem_write;
  assign timeout_c      = (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
  assign dm_addr        = {addr[DM_AW-1:2], 2'b00};
  assign dm_be          = lane.be;
  assign dm_wdata       = lane.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wd_cnt_d   = '0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    done       = 1'b0;
    stall      = 1'b0;
    load_data  = '0;
    access_err = 1'b0;
    bus_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_c && !legal) begin
          access_err = 1'b1;
          done       = 1'b1;
        end else if (access_c) begin
          dm_req = 1'b1;
          dm_we  = mem_write;
          if (mem_write && dm_gnt) begin
            done = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = (mem_read && dm_gnt) ? WAIT_RDATA : WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (dm_gnt && mem_write) begin
          dm_req  = 1'b1;
          dm_we   = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end else if (timeout_c) begin
          bus_err = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          dm_req = 1'b1;
          dm_we  = mem_write;
          stall  = 1'b1;
          if (dm_gnt) state_d = WAIT_RDATA;
        end
      end
      WAIT_RDATA: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (dm_rvalid) begin
          done      = 1'b1;
          load_data = ext_data;
          state_d   = IDLE;
        end else if (timeout_c) begin
          bus_err = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) wd_cnt_d = '0;
    // Outputs fall immediately when reset asserts, even with a live access on the inputs
    if (!rst_n) begin
      dm_req     = 1'b0;
      dm_we      = 1'b0;
      done       = 1'b0;
      stall      = 1'b0;
      load_data  = '0;
      access_err = 1'b0;
      bus_err    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: vector table driven through a scoreboard queue.
module tb_mem_stage_lsu;

  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] addr, store_data;
  logic        dm_req, dm_we;
  logic [8:0]  dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic [31:0] load_data;
  logic        done, stall, access_err, bus_err;

  int checks   = 0;
  int failures = 0;

  mem_stage_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .func3      (func3),
    .addr       (addr),
    .store_data (store_data),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_be      (dm_be),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .load_data  (load_data),
    .done       (done),
    .stall      (stall),
    .access_err (access_err),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          g;
    int          r;
    logic        spur;
    logic [1:0]  kind;
    logic [8:0]  e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_ld;
    int          e_stall;
  } vec_t;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] ld;
    int          stall;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h @%0t", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                              input int g, input int r, input logic spur, input logic [1:0] kind,
                              input logic [8:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wd, input logic [31:0] e_ld, input int e_stall);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.sd = sd; v.rdata = rdat;
    v.g = g; v.r = r; v.spur = spur; v.kind = kind;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wd = e_wd; v.e_ld = e_ld; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b000; addr = '0; store_data = '0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    exp_t e;
    bit   got_done = 1'b0;
    bit   req_seen = 1'b0;
    bit   lz_bad   = 1'b0;
    int   stall_n  = 0;
    int   rv_c;
    e.kind = v.kind; e.ld = v.e_ld; e.stall = v.e_stall;
    sb_q.push_back(e);
    rv_c = (v.r == NEVER || v.g == NEVER) ? -1 : v.g + 1 + v.r;
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(negedge clk);
      mem_read = v.rd; mem_write = v.wr; func3 = v.f3; addr = v.addr; store_data = v.sd;
      dm_gnt    = (c == v.g);
      dm_rvalid = (v.rd && c == rv_c) || (v.spur && c <= v.g);
      dm_rdata  = (c == rv_c) ? v.rdata : 32'h5A5A_5A5A;
      #2;
      if (dm_req && !req_seen) begin
        req_seen = 1'b1;
        check({name, ".dm_addr"},  32'(dm_addr), 32'(v.e_addr));
        check({name, ".dm_be"},    32'(dm_be), 32'(v.e_be));
        check({name, ".dm_wdata"}, dm_wdata, v.e_wd);
        check({name, ".dm_we"},    32'(dm_we), 32'(v.wr));
      end
      if (stall) stall_n++;
      if (!done && load_data != 32'd0) lz_bad = 1'b1;
      if (done) begin
        got_done = 1'b1;
        e = sb_q.pop_front();
        check({name, ".err_kind"},  32'({bus_err, access_err}), 32'(e.kind));
        check({name, ".load_data"}, load_data, e.ld);
        check({name, ".stall_cyc"}, 32'(stall_n), 32'(e.stall));
      end
    end
    if (!got_done) begin
      check({name, ".done_seen"}, 32'd0, 32'd1);
      e = sb_q.pop_front();
    end
    check({name, ".req_seen"}, 32'(req_seen), 32'(v.kind != 2'b01));
    check({name, ".ld_zero_not_done"}, 32'(lz_bad), 32'd0);
    @(negedge clk);
    idle_inputs();
    #2;
    check({name, ".idle_after"}, 32'({dm_req, stall, done, access_err, bus_err}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_000C, 32'hDEAD_BEEF, 0, 0, NEVER, 0, 2'b00, 9'h00C, 4'b1111, 32'hDEAD_BEEF, 0, 0));
    vecs.push_back(mk(0, 1, 3'b000, 32'h0000_0005, 32'h0000_00A5, 0, 2, NEVER, 0, 2'b00, 9'h004, 4'b0010, 32'hA5A5_A5A5, 0, 2));
    vecs.push_back(mk(1, 0, 3'b000, 32'h0000_0007, 0, 32'h80FF_1234, 0, 0, 0, 2'b00, 9'h004, 4'b1000, 0, 32'hFFFF_FF80, 1));
    vecs.push_back(mk(1, 0, 3'b100, 32'h0000_0007, 0, 32'h80FF_1234, 1, 1, 1, 2'b00, 9'h004, 4'b1000, 0, 32'h0000_0080, 3));
    vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0006, 0, 32'h80FF_1234, 0, 2, 0, 2'b00, 9'h004, 4'b1100, 0, 32'h0000_80FF, 3));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0000, 0, 32'h0000_8001, 0, 0, 0, 2'b00, 9'h000, 4'b0011, 0, 32'hFFFF_8001, 1));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0008, 0, 32'hCAFE_F00D, 3, 1, 0, 2'b00, 9'h008, 4'b1111, 0, 32'hCAFE_F00D, 5));
    vecs.push_back(mk(0, 1, 3'b001, 32'h0000_0006, 32'h0000_BEEF, 0, 1, NEVER, 0, 2'b00, 9'h004, 4'b1100, 32'hBEEF_BEEF, 0, 1));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0E0C, 32'h1357_9BDF, 0, 0, NEVER, 0, 2'b00, 9'h00C, 4'b1111, 32'h1357_9BDF, 0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0006, 0, 0, 0, NEVER, 0, 2'b01, 9'h000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0003, 0, 0, 0, NEVER, 0, 2'b01, 9'h000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b011, 32'h0000_0000, 0, 0, 0, NEVER, 0, 2'b01, 9'h000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'b100, 32'h0000_0000, 0, 0, 0, NEVER, 0, 2'b01, 9'h000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h0000_0000, 0, 0, 0, NEVER, 0, 2'b01, 9'h000, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0010, 0, 0, 0, NEVER, 0, 2'b10, 9'h010, 4'b1111, 0, 0, 16));
    vecs.push_back(mk(0, 1, 3'b010, 32'h0000_0014, 32'h0BAD_CAFE, 0, NEVER, NEVER, 0, 2'b10, 9'h014, 4'b1111, 32'h0BAD_CAFE, 0, 16));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("reset.dm_req", 32'(dm_req), 32'd0);
    check("reset.stall",  32'(stall), 32'd0);
    check("reset.done",   32'(done), 32'd0);
    check("reset.errs",   32'({access_err, bus_err}), 32'd0);
    check("reset.load",   load_data, 32'd0);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset while a read waits for rvalid
    @(negedge clk);
    mem_read = 1'b1; func3 = 3'b010; addr = 32'h20; dm_gnt = 1'b1;
    #2;
    check("rst_mid.req_stall", 32'({dm_req, stall}), 32'b11);
    @(negedge clk);
    dm_gnt = 1'b0;
    #2;
    check("rst_mid.wait_rdata", 32'({dm_req, stall}), 32'b01);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid.dropped", 32'({dm_req, stall, done}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #2;
    check("rst_mid.idle", 32'({dm_req, stall, done}), 32'd0);
    run_vec("post_rst_lw", mk(1, 0, 3'b010, 32'h0, 0, 32'h2468_ACE0, 0, 0, 0, 2'b00, 9'h000, 4'b1111, 0, 32'h2468_ACE0, 1));

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
